// File: rtl/wide_addsub_seq.sv
// Chunk-serial wide adder/subtractor: captures operands on start, then
// processes one CHUNK-bit slice per clock, least-significant slice first.
module wide_addsub_seq #(
    parameter int unsigned WIDTH = 400,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             done
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SUM_W  = CHUNK + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    int unsigned      base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;
    logic             last;
    logic             ovf_c;

    // Slice adder for the current chunk; b_r already holds ~b in subtract mode.
    always_comb begin
        base               = 32'(idx_q) * CHUNK;
        chunk_a            = a_r[base +: CHUNK];
        chunk_b            = b_r[base +: CHUNK];
        {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + SUM_W'(carry_q);
        last               = (idx_q == IDX_W'(NCHUNK - 1));
        ovf_c              = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                             (chunk_s[CHUNK-1] != a_r[WIDTH-1]);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        carry_q <= sub;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    sum[base +: CHUNK] <= chunk_s;
                    carry_q            <= chunk_c;
                    idx_q              <= idx_q + IDX_W'(1);
                    if (last) begin
                        carry_out <= chunk_c;
                        overflow  <= ovf_c;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        idx_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture; contents are don't-care until a start is accepted.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start && !rst) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
        end
    end

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Scoreboard bench: three DUT instances (CHUNK = 8, 400, 1) run directed and
// random back-to-back operations against an arithmetic reference model.
module tb_wide_addsub_seq;

    localparam int unsigned W = 400;
    localparam time PERIOD = 10;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        time          t0;
        bit           ch;
    } exp_t;

    logic clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_fin = 0;

    task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the full-width values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        logic [W:0] u;
        logic signed [W+1:0] r;
        logic signed [W+1:0] sx;
        logic signed [W+1:0] sy;
        sx = $signed({{2{x[W-1]}}, x});
        sy = $signed({{2{y[W-1]}}, y});
        if (!s) begin
            u    = {1'b0, x} + {1'b0, y};
            e.s  = u[W-1:0];
            e.co = u[W];
            r    = sx + sy;
        end else begin
            e.s  = x - y;
            e.co = (x >= y);
            r    = sx - sy;
        end
        e.ov = (r != $signed({{2{e.s[W-1]}}, e.s}));
        e.t0 = 0;
        e.ch = 1'b0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        case ($urandom % 8)
            0: v = '1;
            1: v = '0;
            2: begin v = '0; v[W-1] = 1'b1; end
            3: begin v = '1; v[W-1] = 1'b0; end
            default: for (int i = 0; i < W/16; i++) v[i*16 +: 16] = 16'($urandom);
        endcase
        return v;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned CK = (g == 0) ? 8 : (g == 1) ? 400 : 1;
        localparam int unsigned N  = W / CK;
        localparam int NRAND = (g == 0) ? 150 : (g == 1) ? 1000 : 60;
        localparam int RST_K = (N > 20) ? 19 : 0;

        logic         rst = 1'b1;
        logic         start = 1'b0;
        logic         sub = 1'b0;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         busy;
        logic [W-1:0] sum;
        logic         carry_out;
        logic         overflow;
        logic         done;
        exp_t         q[$];
        time          last_done = 0;

        wide_addsub_seq #(.WIDTH(W), .CHUNK(CK)) u_dut (
            .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
            .busy(busy), .sum(sum), .carry_out(carry_out),
            .overflow(overflow), .done(done)
        );

        // Waits for idle while scrambling inputs, then issues one operation.
        task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic is, input bit hold);
            int guard = 0;
            exp_t e;
            while (busy === 1'b1 && guard < 2*N + 10) begin
                a = rnd(); b = rnd(); sub = 1'($urandom);
                start = hold ? 1'b1 : 1'($urandom);
                @(negedge clk);
                guard++;
            end
            if (guard >= 2*N + 10) chk($sformatf("c%0d idle_timeout", CK), 1, 0);
            e = model(ia, ib, is);
            e.ch = hold && start === 1'b1 && done === 1'b1;
            start = 1'b1; a = ia; b = ib; sub = is;
            @(posedge clk);
            e.t0 = $time;
            q.push_back(e);
            @(negedge clk);
            if (!hold) start = 1'b0;
        endtask

        initial begin
            logic [W-1:0] ones;
            logic [W-1:0] msb;
            int guard;
            ones = '1;
            msb = '0; msb[W-1] = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk($sformatf("c%0d rst_busy", CK), busy, 0);
            chk($sformatf("c%0d rst_done", CK), done, 0);
            chk($sformatf("c%0d rst_sum", CK), sum, 0);
            chk($sformatf("c%0d rst_co", CK), carry_out, 0);
            chk($sformatf("c%0d rst_ov", CK), overflow, 0);
            rst = 1'b0;

            issue(ones, 1, 1'b0, 1'b0);
            issue(5, 7, 1'b1, 1'b0);
            issue(7, 5, 1'b1, 1'b0);
            issue(msb - 1, 1, 1'b0, 1'b0);
            issue(msb, 1, 1'b1, 1'b0);

            // Abort an operation part-way with reset.
            issue(rnd(), rnd(), 1'($urandom), 1'b0);
            repeat (RST_K) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            q.delete();
            @(negedge clk);
            chk($sformatf("c%0d abort_busy", CK), busy, 0);
            chk($sformatf("c%0d abort_done", CK), done, 0);
            chk($sformatf("c%0d abort_sum", CK), sum, 0);
            chk($sformatf("c%0d abort_co", CK), carry_out, 0);
            chk($sformatf("c%0d abort_ov", CK), overflow, 0);
            rst = 1'b0;
            issue(ones, ones, 1'b0, 1'b0);

            for (int i = 0; i < NRAND; i++) issue(rnd(), rnd(), 1'($urandom), 1'b1);
            start = 1'b0;

            guard = 0;
            while (q.size() > 0 && guard < 2*N + 10) begin
                @(negedge clk);
                guard++;
            end
            chk($sformatf("c%0d drain", CK), q.size(), 0);
            n_fin++;
        end

        always @(negedge clk) begin
            exp_t e;
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk($sformatf("c%0d unexpected_done", CK), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("c%0d sum", CK), sum, e.s);
                    chk($sformatf("c%0d carry_out", CK), carry_out, e.co);
                    chk($sformatf("c%0d overflow", CK), overflow, e.ov);
                    chk($sformatf("c%0d latency", CK), ($time - PERIOD/2 - e.t0) / PERIOD, N);
                    chk($sformatf("c%0d busy_at_done", CK), busy, 0);
                    if (e.ch) chk($sformatf("c%0d done_spacing", CK), ($time - last_done) / PERIOD, N + 1);
                end
                last_done = $time;
            end else if (q.size() > 0) begin
                chk($sformatf("c%0d busy_run", CK), busy, 1);
            end
        end
    end

    initial begin
        int cyc = 0;
        while (n_fin < 3 && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        if (n_fin < 3) chk("global_timeout", n_fin, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wide_addsub_seq.md
# wide_addsub_seq

Multi-cycle, chunk-serial wide adder/subtractor, parametrised in operand width and chunk width. It is the next generation of the team's 400-bit chunked adder. It adds a subtract mode, operand capture on start, a busy/done handshake, carry-out and signed-overflow flags. One CHUNK-bit slice is processed per clock, so a small adder can serve arbitrarily wide operands in datapaths such as bignum, crypto and accumulator chains.

## Interface
- WIDTH, 400, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while idle (busy=0).
- sub  in  1  mode, captured with start: 0 = a+b, 1 = a−b.
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- busy  out  1  high while an operation is in progress.
- sum  out  WIDTH  result register, modulo 2^WIDTH.
- carry_out  out  1  final carry; in sub mode 1 = no borrow (a ≥ b unsigned).
- overflow  out  1  two's-complement signed overflow of the full-width result.
- done  out  1  single-cycle pulse marking the result valid.

## Operation
- States: IDLE, RUN.
- Reset (rst=1 at an edge) takes priority over everything:
  - state ← IDLE, chunk index ← 0, internal carry ← 0.
  - sum ← 0, carry_out ← 0, overflow ← 0, busy ← 0, done ← 0.
- IDLE, start=1 at an edge:
  - capture a into A_r.
  - capture b (or ~b if sub=1) into B_r.
  - carry ← sub, index ← 0, busy ← 1, state ← RUN.
- IDLE, start=0: hold all outputs; done ← 0.
- RUN, each edge:
  - compute {c, s} = A_r[idx*CHUNK +: CHUNK] + B_r[idx*CHUNK +: CHUNK] + carry, which is CHUNK+1 bits wide.
  - write sum[idx*CHUNK +: CHUNK] ← s, carry ← c, idx ← idx+1.
- RUN, edge where idx = NCHUNK−1:
  - also set carry_out ← c.
  - set overflow ← (A_r[WIDTH−1] == B_r[WIDTH−1]) && (s[CHUNK−1] != A_r[WIDTH−1]), using the inverted B_r in sub mode.
  - done ← 1, busy ← 0, idx ← 0, state ← IDLE.
- start, sub, a and b are ignored while busy. Input changes after capture have no effect.
- sum is updated chunk by chunk during RUN. It is defined as valid only from the done cycle until the next accepted start.
- carry_out and overflow hold their values until the next completion or reset.
- Reset mid-operation aborts: no done pulse, and outputs are at their reset values on the following cycle.

## Timing
- Start accepted at edge E0; busy high from E0 to E(NCHUNK).
- Chunk k is written at edge E(k+1).
- At edge E(NCHUNK): done=1, sum/carry_out/overflow final, busy=0.
- done is high for exactly one cycle, between E(NCHUNK) and E(NCHUNK+1).
- Latency is NCHUNK cycles from the start edge to done high (default 50).
- Back-to-back: start held high during the done cycle is accepted at E(NCHUNK+1). Throughput is one op per NCHUNK+1 cycles.
- start asserted during busy is dropped, not queued.
- NCHUNK=1 case: busy high for one cycle, done on the next edge.

## Test plan
- Carry across all chunks: WIDTH=400, CHUNK=8, a=2^400−1, b=1, sub=0.
  - Expect sum=0, carry_out=1, overflow=0.
  - Expect done exactly 50 cycles after the start edge and busy high for 50 cycles.
- Borrow: sub=1, a=5, b=7.
  - Expect sum=2^400−2, carry_out=0, overflow=0.
  - sub=1, a=7, b=5 → sum=2, carry_out=1.
- Signed overflow:
  - a=2^399−1, b=1, add → sum=2^399, overflow=1, carry_out=0.
  - a=2^399, b=1, sub → sum=2^399−1, overflow=1.
- Capture/ignore:
  - Change a, b and sub every cycle during RUN, and pulse start mid-op.
  - Expect the result to match the captured operands and exactly one done pulse.
- Reset mid-op: assert rst at cycle 20 of RUN.
  - Expect busy=0, sum=0, carry_out=0, overflow=0 after the edge, and no done pulse.
  - A new op afterwards completes correctly.
- Parameter sweep: CHUNK=400 (NCHUNK=1) and CHUNK=1 (NCHUNK=400), WIDTH=400.
  - Run 1000 random add/sub ops, back-to-back with start held high.
  - Compare against a reference model: done spacing equals NCHUNK+1 cycles, and sum/carry_out/overflow match.
